// File: rtl/unsigned_shift_add_multiplier_pkg.sv
// ============================================================================
// mul_pkg : shared types and constants for the shift-add multiplier
// Revision: 1.0
// ============================================================================
`default_nettype none

package mul_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CALC = 2'd2,
    DONE = 2'd3
  } state_t;

  // The step counter must be able to hold WIDTH without wrapping
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/unsigned_shift_add_multiplier_if.sv
// ============================================================================
// unsigned_shift_add_multiplier_if : run/rdy operand and result bundle
// Revision: 1.0
// ============================================================================
`default_nettype none

interface unsigned_shift_add_multiplier_if #(
  parameter int WIDTH = 32
);

  logic               run;
  logic [WIDTH-1:0]   multiplicand;
  logic [WIDTH-1:0]   multiplier;
  logic [2*WIDTH-1:0] product;
  logic               rdy;
  logic               busy;

  modport master (
    output run, multiplicand, multiplier,
    input  product, rdy, busy
  );

  modport slave (
    input  run, multiplicand, multiplier,
    output product, rdy, busy
  );

endinterface

`default_nettype wire

// File: rtl/unsigned_shift_add_multiplier_control.sv
// ============================================================================
// multiplier_control : IDLE/LOAD/CALC/DONE sequencer and step counter
// Revision: 1.0
// ============================================================================
`default_nettype none

module multiplier_control
  import mul_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic i_run,
  input  wire logic i_zero,
  output logic      o_rdy,
  output logic      o_busy,
  output logic      o_load_en,
  output logic      o_step_en,
  output logic      o_zero_en
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_t           r_state;
  logic [CNT_W-1:0] r_count;
  logic             r_rdy;
  logic             r_busy;

  assign o_rdy     = r_rdy;
  assign o_busy    = r_busy;
  assign o_load_en = (r_state == IDLE) && i_run;
  assign o_step_en = (r_state == CALC) && i_run;
  assign o_zero_en = (r_state == LOAD) && i_zero;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_count <= '0;
      r_rdy   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_rdy  <= 1'b0;
          r_busy <= 1'b0;
          if (i_run) begin
            r_state <= LOAD;
            r_count <= '0;
            r_busy  <= 1'b1;
          end
        end
        LOAD: begin
          if (i_zero) begin
            r_state <= DONE;
            r_rdy   <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_state <= CALC;
          end
        end
        CALC: begin
          // run low freezes the step: counter and product both hold
          if (i_run) begin
            r_count <= r_count + CNT_W'(1);
            if (r_count == CNT_W'(WIDTH - 1)) begin
              r_state <= DONE;
              r_rdy   <= 1'b1;
              r_busy  <= 1'b0;
            end
          end
        end
        DONE: begin
          if (!i_run) begin
            r_state <= IDLE;
            r_rdy   <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/unsigned_shift_add_multiplier.sv
// ============================================================================
// unsigned_shift_add_multiplier : WIDTH x WIDTH sequential shift-add multiply
// Optional: MUL_ZERO_SKIP_EN finishes in LOAD when either operand is zero
// Revision: 1.0
// ============================================================================
`default_nettype none

module unsigned_shift_add_multiplier
  import mul_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  wire logic                   clk,
  input  wire logic                   rst,
  unsigned_shift_add_multiplier_if.slave bus
);

  logic [WIDTH-1:0]   r_mcand;
  logic [2*WIDTH-1:0] r_product;
  logic [WIDTH:0]     w_sum;
  logic               w_zero;
  logic               w_load_en;
  logic               w_step_en;
  logic               w_zero_en;

`ifdef MUL_ZERO_SKIP_EN
  assign w_zero = (r_mcand == '0) || (r_product[WIDTH-1:0] == '0);
`else
  assign w_zero = 1'b0;
`endif

  // Carry out of the upper half becomes the new MSB after the shift
  assign w_sum = {1'b0, r_product[2*WIDTH-1:WIDTH]}
               + ({1'b0, r_mcand} & {(WIDTH+1){r_product[0]}});

  multiplier_control #(
    .WIDTH(WIDTH)
  ) u_control (
    .clk      (clk),
    .rst      (rst),
    .i_run    (bus.run),
    .i_zero   (w_zero),
    .o_rdy    (bus.rdy),
    .o_busy   (bus.busy),
    .o_load_en(w_load_en),
    .o_step_en(w_step_en),
    .o_zero_en(w_zero_en)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mcand   <= '0;
      r_product <= '0;
    end else if (w_load_en) begin
      r_mcand   <= bus.multiplicand;
      r_product <= {{WIDTH{1'b0}}, bus.multiplier};
    end else if (w_zero_en) begin
      r_product <= '0;
    end else if (w_step_en) begin
      r_product <= {w_sum, r_product[WIDTH-1:1]};
    end
  end

  assign bus.product = r_product;

endmodule

`default_nettype wire

// File: tb/tb_unsigned_shift_add_multiplier.sv
// ============================================================================
// tb_unsigned_shift_add_multiplier : scoreboard bench for the 32-bit multiplier
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_unsigned_shift_add_multiplier;

  localparam int WIDTH = 32;
`ifdef MUL_ZERO_SKIP_EN
  localparam int ZERO_LAT = 1;
`else
  localparam int ZERO_LAT = WIDTH + 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  unsigned_shift_add_multiplier_if #(.WIDTH(WIDTH)) bus ();

  unsigned_shift_add_multiplier #(
    .WIDTH(WIDTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [2*WIDTH-1:0] sb_q[$];
  logic [2*WIDTH-1:0] last_prod;

  task automatic check_val(input string tag, input logic [2*WIDTH-1:0] obs,
                           input logic [2*WIDTH-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // idx counts rising edges after the run-sampling edge (edge 0 gives idx 0)
  task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input int pause_at, input int pause_len, input int exp_lat);
    int idx;
    int busy_cnt;
    bit seen;
    logic [2*WIDTH-1:0] exp;
    bus.multiplicand = a;
    bus.multiplier   = b;
    bus.run          = 1'b1;
    sb_q.push_back(64'(a) * 64'(b));
    idx = -1;
    busy_cnt = 0;
    seen = 1'b0;
    while (!seen && idx < 300) begin
      @(negedge clk);
      idx++;
      if (bus.rdy) seen = 1'b1;
      else if (bus.busy) busy_cnt++;
      if (pause_len > 0 && idx == pause_at) bus.run = 1'b0;
      if (pause_len > 0 && idx == pause_at + pause_len) bus.run = 1'b1;
      if (idx == 0) begin
        bus.multiplicand = ~a;
        bus.multiplier   = ~b;
      end
    end
    check_val("rdy_seen", 64'(seen), 64'(1));
    check_val("latency", 64'(idx), 64'(exp_lat));
    check_val("busy_cycles", 64'(busy_cnt), 64'(exp_lat));
    exp = sb_q.pop_front();
    check_val("product", bus.product, exp);
    last_prod = exp;
  endtask

  task automatic end_op();
    bus.run = 1'b0;
    @(negedge clk);
    check_val("rdy_clear", 64'(bus.rdy), 64'(0));
    check_val("prod_retained", bus.product, last_prod);
  endtask

  initial begin
    bus.run = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier = '0;
    last_prod = '0;
    repeat (2) @(negedge clk);
    check_val("rst_product", bus.product, 64'(0));
    check_val("rst_rdy", 64'(bus.rdy), 64'(0));
    check_val("rst_busy", 64'(bus.busy), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    do_op(32'd3, 32'd5, 0, 0, WIDTH + 1);
    end_op();

    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, WIDTH + 1);
    check_val("all_ones", bus.product, 64'hFFFF_FFFE_0000_0001);
    end_op();

    do_op(32'd7, 32'd9, 5, 5, WIDTH + 6);
    // Hold in DONE while operands change
    bus.multiplicand = 32'd100;
    bus.multiplier   = 32'd200;
    repeat (4) @(negedge clk);
    check_val("done_hold_rdy", 64'(bus.rdy), 64'(1));
    check_val("done_hold_prod", bus.product, 64'd63);
    end_op();
    repeat (3) @(negedge clk);
    check_val("idle_prod_kept", bus.product, 64'd63);

    // Abort mid-CALC with reset
    bus.multiplicand = 32'd12;
    bus.multiplier   = 32'd12;
    bus.run          = 1'b1;
    repeat (12) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_val("midrst_product", bus.product, 64'(0));
    check_val("midrst_rdy", 64'(bus.rdy), 64'(0));
    check_val("midrst_busy", 64'(bus.busy), 64'(0));
    rst = 1'b0;
    bus.run = 1'b0;
    @(negedge clk);
    check_val("post_rst_idle", 64'(bus.busy), 64'(0));
    do_op(32'd2, 32'd4, 0, 0, WIDTH + 1);
    end_op();

    do_op(32'd0, 32'd123, 0, 0, ZERO_LAT);
    end_op();
    do_op(32'd77, 32'd0, 0, 0, ZERO_LAT);
    end_op();

    for (int i = 0; i < 4; i++) begin
      do_op($urandom, $urandom, 0, 0, WIDTH + 1);
      end_op();
    end

    check_val("sb_empty", 64'(sb_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
